// File: rtl/num_gen_pkg.sv
// num_gen_pkg: shared state encoding, digit limits and count-step helper for num_gen_0_2.
package num_gen_pkg;
    typedef enum logic {ST_PAUSE = 1'b0, ST_RUN = 1'b1} state_e;
    localparam logic [1:0] NUM_MAX   = 2'd2;
    localparam logic [1:0] NUM_BLANK = 2'b11;
    // returns {wrap, next} for one step of the 0..NUM_MAX ring in the given direction
    function automatic logic [2:0] step_count(input logic [1:0] c, input logic down);
        return down ? ((c == 2'd0) ? {1'b1, NUM_MAX} : {1'b0, c - 2'd1})
                    : ((c == NUM_MAX) ? 3'b100 : {1'b0, c + 2'd1});
    endfunction
endpackage

// File: rtl/num_gen_0_2_key_debounce.sv
// key_debounce: 2-flop synchroniser, DB_CYCLES debounce and one-cycle press pulse on debounced 1->0.
module key_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    logic sync1_q, sync2_q, db_q, db_d, press_q, press_d, flip;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        flip    = (sync2_q != db_q) && (cnt_q == CNT_LAST);
        cnt_d   = (sync2_q == db_q || flip) ? '0 : cnt_q + 1'b1;
        db_d    = flip ? sync2_q : db_q;
        press_d = flip && db_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end
    assign press = press_q;
endmodule

// File: rtl/num_gen_0_2.sv
// num_gen_0_2: 0..2 digit counter with RUN/PAUSE control, debounced keys and wrap carry.
// Define BLINK_PAUSE_EN to blank the digit in the second half of each tick period while paused.
module num_gen_0_2
    import num_gen_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_run_n,
    input  logic       key_step_n,
    input  logic       sw_dir,
    output logic [1:0] num,
    output logic       running,
    output logic       carry
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    logic run_p, step_p, dir_s1_q, dir_q, tick, adv, carry_q, carry_d;
    logic [2:0] stepped;
    logic [1:0] count_q, count_d, num_q, num_d;
    logic [PW-1:0] pre_q, pre_d;
    state_e state_q, state_d;

    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_run  (.clk(clk), .rst_n(rst_n), .key_n(key_run_n),  .press(run_p));
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (.clk(clk), .rst_n(rst_n), .key_n(key_step_n), .press(step_p));

    // a run press always wins: it suppresses both the tick advance and a coincident step
    always_comb begin
        tick    = pre_q == PRE_LAST;
        state_d = run_p ? ((state_q == ST_RUN) ? ST_PAUSE : ST_RUN) : state_q;
        adv     = !run_p && ((state_q == ST_RUN) ? tick : step_p);
        stepped = step_count(count_q, dir_q);
        count_d = adv ? stepped[1:0] : count_q;
        carry_d = adv && stepped[2];
        pre_d   = (tick || (run_p && state_q == ST_PAUSE)) ? '0 : pre_q + 1'b1;
`ifdef BLINK_PAUSE_EN
        num_d   = (state_d == ST_PAUSE && pre_d >= PW'(TICK_DIV / 2)) ? NUM_BLANK : count_d;
`else
        num_d   = count_d;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_PAUSE;
            count_q  <= 2'd0;
            num_q    <= 2'd0;
            carry_q  <= 1'b0;
            pre_q    <= '0;
            dir_s1_q <= 1'b1;
            dir_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            num_q    <= num_d;
            carry_q  <= carry_d;
            pre_q    <= pre_d;
            dir_s1_q <= sw_dir;
            dir_q    <= dir_s1_q;
        end
    end

    assign num     = num_q;
    assign running = state_q == ST_RUN;
    assign carry   = carry_q;
endmodule

// File: tb/tb_num_gen_0_2.sv
// tb_num_gen_0_2: directed stimulus pushes timed expected output changes; a monitor pops on every output change.
module tb_num_gen_0_2;
    logic clk = 1'b0, rst_n = 1'b1, key_run_n = 1'b1, key_step_n = 1'b1, sw_dir = 1'b0;
    logic [1:0] num;
    logic running, carry;
    int cyc = 0, total = 0, bad = 0;

    typedef struct {
        int at;
        logic [1:0] num;
        logic run;
        logic carry;
    } exp_t;
    exp_t sb[$];

    num_gen_0_2 #(.TICK_DIV(8), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .key_run_n(key_run_n), .key_step_n(key_step_n),
        .sw_dir(sw_dir), .num(num), .running(running), .carry(carry)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic expect_at(input int at, input logic [1:0] n, input logic r, input logic c);
        sb.push_back('{at, n, r, c});
    endtask

    // monitor: any change of {num,running,carry} consumes one expected event
    initial begin
        exp_t e;
        logic [3:0] cur, prev;
        bit first;
        int ev;
        first = 1'b1;
        prev = 4'd0;
        ev = 0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            cur = {num, running, carry};
            if (first || cur != prev) begin
                first = 1'b0;
                prev = cur;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got num=%0d running=%0b carry=%0b", cyc, num, running, carry);
                end else begin
                    e = sb.pop_front();
                    if ((e.at >= 0 && e.at != cyc) || e.num != num || e.run != running || e.carry != carry) begin
                        bad++;
                        $display("FAIL ev%0d got cyc=%0d num=%0d running=%0b carry=%0b want cyc=%0d num=%0d running=%0b carry=%0b",
                                 ev, cyc, num, running, carry, e.at, e.num, e.run, e.carry);
                    end
                end
                ev++;
            end
        end
    end

    initial begin
        int c;
        expect_at(-1, 2'd0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(50);
        // run press: RUN after 7 cycles, then up-count every 8 cycles with carry on 2->0
        c = cyc;
        key_run_n = 1'b0;
        expect_at(c + 7, 2'd0, 1'b1, 1'b0);
        expect_at(c + 15, 2'd1, 1'b1, 1'b0);
        expect_at(c + 23, 2'd2, 1'b1, 1'b0);
        expect_at(c + 31, 2'd0, 1'b1, 1'b1);
        expect_at(c + 32, 2'd0, 1'b1, 1'b0);
        cycles(10);
        key_run_n = 1'b1;
        cycles(22);
        // second run press lands exactly on a tick: pause, no advance
        c = cyc;
        key_run_n = 1'b0;
        expect_at(c + 7, 2'd0, 1'b0, 1'b0);
        cycles(10);
        key_run_n = 1'b1;
        cycles(10);
        // 3-cycle glitch is filtered
        key_run_n = 1'b0;
        cycles(3);
        key_run_n = 1'b1;
        cycles(20);
        // paused down-steps: 0->2 with carry, 2->1 without
        sw_dir = 1'b1;
        cycles(5);
        c = cyc;
        key_step_n = 1'b0;
        expect_at(c + 7, 2'd2, 1'b0, 1'b1);
        expect_at(c + 8, 2'd2, 1'b0, 1'b0);
        cycles(6);
        key_step_n = 1'b1;
        cycles(14);
        c = cyc;
        key_step_n = 1'b0;
        expect_at(c + 7, 2'd1, 1'b0, 1'b0);
        cycles(6);
        key_step_n = 1'b1;
        cycles(14);
        // simultaneous run+step: run wins, count held, first advance 8 cycles later
        c = cyc;
        sw_dir = 1'b0;
        key_run_n = 1'b0;
        key_step_n = 1'b0;
        expect_at(c + 7, 2'd1, 1'b1, 1'b0);
        expect_at(c + 15, 2'd2, 1'b1, 1'b0);
        expect_at(c + 23, 2'd0, 1'b1, 1'b1);
        expect_at(c + 24, 2'd0, 1'b1, 1'b0);
        expect_at(c + 31, 2'd1, 1'b1, 1'b0);
        expect_at(c + 39, 2'd2, 1'b1, 1'b0);
        cycles(6);
        key_run_n = 1'b1;
        key_step_n = 1'b1;
        cycles(35);
        // asynchronous reset mid-run at num=2, between clock edges
        #1;
        expect_at(cyc, 2'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(10);
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_event got none want cyc=%0d num=%0d running=%0b carry=%0b", e.at, e.num, e.run, e.carry);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
